// File: rtl/code_decoder_seq_pkg.sv
// rtl/code_decoder_seq_pkg.sv - shared types, constants and decode helper for code_decoder_seq
// Purpose: state encoding, code/line widths shared with the 7-input priority
// encoder, and the code-to-one-hot decode function.
package code_decoder_seq_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Code k in 1..7 selects line k-1; code 0 selects no line.
  function automatic logic [LINES-1:0] decode_code(input logic [CODE_W-1:0] code);
    logic [LINES-1:0] lines;
    lines = '0;
    for (int i = 0; i < LINES; i++) begin
      if (code == CODE_W'(i + 1)) lines[i] = 1'b1;
    end
    return lines;
  endfunction

endpackage

// File: rtl/code_decoder_seq_hold_timer.sv
// rtl/code_decoder_seq_hold_timer.sv - loadable down-counter timing the HOLD and GAP phases
// Purpose: CNT_W-bit down-counter; load has priority over decrement, and the
// count saturates at zero.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (count <= 0)
//   load     in   load load_val this cycle
//   load_val in   CNT_W value to load
//   dec      in   decrement this cycle (ignored when count is zero)
//   zero     out  count == 0
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/code_decoder_seq.sv
// rtl/code_decoder_seq.sv - sequential 3-to-7 decoder with programmable hold and gap
// Purpose: accepts a 3-bit code over valid/ready, drives one-hot a_out[code-1]
// for HOLD_CYCLES cycles, then forces all-zero for GAP_CYCLES cycles.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   code_in     in   code to decode (0 = no line)
//   code_valid  in   code_in valid
//   code_ready  out  block can accept a code (IDLE and not in reset)
//   enable      in   active-high output disable; masks a_out to zero
//   a_out       out  one-hot decoded lines
//   busy        out  1 in HOLD or GAP
//   last_code   out  most recently accepted code
module code_decoder_seq
  import code_decoder_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              enable,
  output logic [LINES-1:0]  a_out,
  output logic              busy,
  output logic [CODE_W-1:0] last_code
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2**CNT_W) - 1 ||
      GAP_CYCLES < 0 || GAP_CYCLES > (2**CNT_W) - 1) begin : g_param_error
    $error("code_decoder_seq: HOLD_CYCLES/GAP_CYCLES out of range for CNT_W");
  end

  // Counter reloads are one less than the phase length since the zero cycle counts.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t             state, next_state;
  logic [LINES-1:0]   a_reg, a_next;
  logic               accept;
  logic               load, dec, zero;
  logic [CNT_W-1:0]   load_val;

  hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  assign code_ready = (state == IDLE) && !rst;
  assign accept     = code_valid && code_ready;
  assign busy       = (state != IDLE);
  assign a_out      = a_reg & {LINES{~enable}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      last_code <= '0;
    end else begin
      state <= next_state;
      a_reg <= a_next;
      if (accept) last_code <= code_in;
    end
  end

  always_comb begin
    next_state = state;
    a_next     = a_reg;
    load       = 1'b0;
    load_val   = '0;
    dec        = 1'b0;
    case (state)
      IDLE: begin
        a_next = '0;
        if (accept && (code_in != '0)) begin
          a_next     = decode_code(code_in);
          load       = 1'b1;
          load_val   = HOLD_LOAD;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (zero) begin
          a_next = '0;
          if (GAP_CYCLES > 0) begin
            load       = 1'b1;
            load_val   = GAP_LOAD;
            next_state = GAP;
          end else begin
            next_state = IDLE;
          end
        end else begin
          dec = 1'b1;
        end
      end
      GAP: begin
        a_next = '0;
        if (zero) next_state = IDLE;
        else      dec = 1'b1;
      end
      default: begin
        a_next     = '0;
        next_state = IDLE;
      end
    endcase
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(a_reg));

endmodule

// File: tb/tb_code_decoder_seq.sv
// tb/tb_code_decoder_seq.sv - self-checking bench for code_decoder_seq
module tb_code_decoder_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst, code_valid, enable;
  logic [2:0] code_in;
  logic       code_ready, busy;
  logic [6:0] a_out;
  logic [2:0] last_code;

  logic       rst1, code_valid1, enable1;
  logic [2:0] code_in1;
  logic       code_ready1, busy1;
  logic [6:0] a_out1;
  logic [2:0] last_code1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_decoder_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .enable(enable), .a_out(a_out), .busy(busy),
    .last_code(last_code)
  );

  code_decoder_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .CNT_W(8)) dut_nogap (
    .clk(clk), .rst(rst1), .code_in(code_in1), .code_valid(code_valid1),
    .code_ready(code_ready1), .enable(enable1), .a_out(a_out1), .busy(busy1),
    .last_code(last_code1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] line_of(input int k);
    logic [6:0] v;
    v = '0;
    if (k >= 1 && k <= 7) v[k-1] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1; rst1 = 1; code_valid = 0; code_valid1 = 0; code_in = 0; code_in1 = 0;
    enable = 0; enable1 = 0;
    tick(); tick();
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", code_ready); end
    checks++; if (a_out !== 7'b0) begin errors++; $display("FAIL reset_a_out got %b exp 0", a_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (last_code !== 3'd0) begin errors++; $display("FAIL reset_last got %0d exp 0", last_code); end
    rst = 0; rst1 = 0;
    #1;
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", code_ready); end
    checks++; if (code_ready1 !== 1'b1) begin errors++; $display("FAIL reset_release_ready1 got %b exp 1", code_ready1); end
  endtask

  task automatic test_code3();
    code_in = 3; code_valid = 1;
    tick();
    code_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      logic [6:0] ea;
      ea = (c <= HOLD) ? 7'b0000100 : 7'b0;
      checks++; if (a_out !== ea) begin errors++; $display("FAIL code3_a_out c%0d got %b exp %b", c, a_out, ea); end
      checks++; if (code_ready !== (c == 6)) begin errors++; $display("FAIL code3_ready c%0d got %b exp %b", c, code_ready, c == 6); end
      checks++; if (busy !== (c < 6)) begin errors++; $display("FAIL code3_busy c%0d got %b exp %b", c, busy, c < 6); end
      if (c < 6) tick();
    end
    checks++; if (last_code !== 3'd3) begin errors++; $display("FAIL code3_last got %0d exp 3", last_code); end
  endtask

  task automatic test_sweep();
    for (int k = 1; k <= 7; k++) begin
      code_in = 3'(k); code_valid = 1;
      tick();
      code_valid = 0;
      for (int c = 1; c <= HOLD; c++) begin
        int enc;
        enc = 0;
        for (int b = 0; b < 7; b++) if (a_out[b] === 1'b1) enc = b + 1;
        checks++; if (enc != k) begin errors++; $display("FAIL sweep_encode k%0d c%0d got %0d exp %0d", k, c, enc, k); end
        tick();
      end
      for (int g = 0; g < GAP; g++) tick();
      checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready k%0d got %b exp 1", k, code_ready); end
    end
  endtask

  task automatic test_code0();
    code_in = 0; code_valid = 1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL code0_ready c%0d got %b exp 1", c, code_ready); end
      tick();
      checks++; if (a_out !== 7'b0) begin errors++; $display("FAIL code0_a_out c%0d got %b exp 0", c, a_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL code0_busy c%0d got %b exp 0", c, busy); end
      checks++; if (last_code !== 3'd0) begin errors++; $display("FAIL code0_last c%0d got %0d exp 0", c, last_code); end
    end
    code_valid = 0;
  endtask

  task automatic test_ignore();
    code_in = 2; code_valid = 1;
    tick();
    code_in = 5;
    for (int c = 1; c <= HOLD + GAP; c++) begin
      logic [6:0] ea;
      ea = (c <= HOLD) ? 7'b0000010 : 7'b0;
      checks++; if (a_out !== ea) begin errors++; $display("FAIL ignore_a_out c%0d got %b exp %b", c, a_out, ea); end
      checks++; if (last_code !== 3'd2) begin errors++; $display("FAIL ignore_last c%0d got %0d exp 2", c, last_code); end
      tick();
    end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL ignore_ready got %b exp 1", code_ready); end
    tick();
    code_valid = 0;
    checks++; if (a_out !== 7'b0010000) begin errors++; $display("FAIL ignore_accept5 got %b exp 0010000", a_out); end
    checks++; if (last_code !== 3'd5) begin errors++; $display("FAIL ignore_last5 got %0d exp 5", last_code); end
    for (int c = 0; c < HOLD + GAP; c++) tick();
  endtask

  task automatic test_enable();
    code_in = 7; code_valid = 1;
    tick();
    code_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      logic [6:0] ea;
      enable = (c == 2 || c == 3);
      #1;
      ea = (c <= HOLD && !(c == 2 || c == 3)) ? 7'b1000000 : 7'b0;
      checks++; if (a_out !== ea) begin errors++; $display("FAIL enable_a_out c%0d got %b exp %b", c, a_out, ea); end
      checks++; if (busy !== (c <= HOLD + GAP)) begin errors++; $display("FAIL enable_busy c%0d got %b exp %b", c, busy, c <= HOLD + GAP); end
      tick();
    end
    enable = 0;
  endtask

  task automatic test_reset_mid();
    code_in = 6; code_valid = 1;
    tick();
    code_valid = 0;
    checks++; if (a_out !== 7'b0100000) begin errors++; $display("FAIL rstmid_c1 got %b exp 0100000", a_out); end
    tick();
    rst = 1;
    tick();
    checks++; if (a_out !== 7'b0) begin errors++; $display("FAIL rstmid_a_out got %b exp 0", a_out); end
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", code_ready); end
    checks++; if (last_code !== 3'd0) begin errors++; $display("FAIL rstmid_last got %0d exp 0", last_code); end
    rst = 0;
    #1;
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got %b exp 1", code_ready); end
    tick();

    code_in1 = 6; code_valid1 = 1;
    tick();
    code_valid1 = 0;
    for (int c = 1; c <= HOLD + 1; c++) begin
      logic [6:0] ea;
      ea = (c <= HOLD) ? 7'b0100000 : 7'b0;
      checks++; if (a_out1 !== ea) begin errors++; $display("FAIL nogap_a_out c%0d got %b exp %b", c, a_out1, ea); end
      checks++; if (code_ready1 !== (c == HOLD + 1)) begin errors++; $display("FAIL nogap_ready c%0d got %b exp %b", c, code_ready1, c == HOLD + 1); end
      tick();
    end
    code_in1 = 6; code_valid1 = 1;
    tick();
    code_valid1 = 0;
    tick();
    rst1 = 1;
    tick();
    checks++; if (a_out1 !== 7'b0) begin errors++; $display("FAIL nogap_rst_a_out got %b exp 0", a_out1); end
    checks++; if (code_ready1 !== 1'b0) begin errors++; $display("FAIL nogap_rst_ready got %b exp 0", code_ready1); end
    checks++; if (last_code1 !== 3'd0) begin errors++; $display("FAIL nogap_rst_last got %0d exp 0", last_code1); end
    rst1 = 0;
    #1;
    checks++; if (code_ready1 !== 1'b1) begin errors++; $display("FAIL nogap_rst_ready_after got %b exp 1", code_ready1); end
  endtask

  // Reference model in absolute cycle numbers: an accept in cycle t of code k
  // lights line k-1 in cycles t+1..t+HOLD and frees the block at t+1+HOLD+GAP.
  task automatic test_random();
    int t, acc_t, acc_code, ready_at, exp_last;
    logic pending;
    rst = 1; code_valid = 0; enable = 0;
    tick();
    rst = 0;
    t = 0; acc_t = -1000; acc_code = 0; ready_at = 0; exp_last = 0; pending = 0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ea;
      logic       er;
      if (!pending && ($urandom_range(0, 2) != 0)) begin
        pending = 1;
        code_in = 3'($urandom_range(0, 7));
      end
      code_valid = pending;
      enable = ($urandom_range(0, 4) == 0);
      #1;
      er = (t >= ready_at);
      ea = (acc_code != 0 && t >= acc_t + 1 && t <= acc_t + HOLD && !enable) ? line_of(acc_code) : 7'b0;
      checks++; if (a_out !== ea) begin errors++; $display("FAIL rand_a_out t%0d got %b exp %b", t, a_out, ea); end
      checks++; if (code_ready !== er) begin errors++; $display("FAIL rand_ready t%0d got %b exp %b", t, code_ready, er); end
      checks++; if (busy !== !er) begin errors++; $display("FAIL rand_busy t%0d got %b exp %b", t, busy, !er); end
      checks++; if (last_code !== 3'(exp_last)) begin errors++; $display("FAIL rand_last t%0d got %0d exp %0d", t, last_code, exp_last); end
      if (pending && er) begin
        exp_last = int'(code_in);
        pending = 0;
        if (code_in != 0) begin
          acc_t = t; acc_code = int'(code_in); ready_at = t + 1 + HOLD + GAP;
        end else begin
          ready_at = t + 1;
        end
      end
      tick();
      t++;
    end
    code_valid = 0; enable = 0;
  endtask

  initial begin
    test_reset();
    test_code3();
    test_sweep();
    test_code0();
    test_ignore();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
